// File: rtl/dvi_timing_gen_if.sv
// Pixel-side bundle: frame source request/response and the sync/DE/RGB feed to the TMDS encoders.
interface dvi_timing_gen_if;
    logic        en;
    logic        pattern_sel;
    logic [23:0] rgb_in;
    logic        pix_req;
    logic [11:0] req_x;
    logic [11:0] req_y;
    logic        frame_start;
    logic [23:0] rgb_out;
    logic        de_out;
    logic        hsync;
    logic        vsync;

    modport master (
        output en, pattern_sel, rgb_in,
        input  pix_req, req_x, req_y, frame_start, rgb_out, de_out, hsync, vsync
    );

    modport slave (
        input  en, pattern_sel, rgb_in,
        output pix_req, req_x, req_y, frame_start, rgb_out, de_out, hsync, vsync
    );
endinterface

// File: rtl/dvi_timing_gen.sv
// DVI raster timing generator: counters, one-cycle-ahead pixel request, and a 2-stage
// pipeline that aligns RGB with DE/HSYNC/VSYNC. Optional internal colour bars.
module dvi_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic            clkin,
    input  logic            rstin,
    dvi_timing_gen_if.slave bus
);
    localparam int unsigned CW      = 12;
    localparam int unsigned PW      = 24;
    localparam int unsigned BW      = 3;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

    // Raster counters and colour-bar segment tracker (follows h_cnt, no divider)
    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic [CW-1:0] seg_q, seg_d;
    logic [BW-1:0] bar_q, bar_d;

    // Stage 0: request side
    logic          pix_req_q, pix_req_d;
    logic [CW-1:0] req_x_q, req_x_d;
    logic [CW-1:0] req_y_q, req_y_d;
    logic          frame_start_q, frame_start_d;
    logic          hs0_q, hs0_d;
    logic          vs0_q, vs0_d;
    logic [BW-1:0] bar0_q, bar0_d;

    // Stage 1: wait for the source's read latency
    logic          de1_q, de1_d;
    logic          hs1_q, hs1_d;
    logic          vs1_q, vs1_d;
    logic [BW-1:0] bar1_q, bar1_d;

    // Stage 2: encoder-facing outputs
    logic          de_q, de_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic [PW-1:0] rgb_q, rgb_d;

    logic          pat_q, pat_d;
    logic [PW-1:0] bar_rgb_c;
    logic          at_origin_c;
    logic          h_act_c;
    logic          v_act_c;

    always_comb begin
        at_origin_c = (h_cnt_q == '0) && (v_cnt_q == '0);
        h_act_c     = h_cnt_q < H_ACT;
        v_act_c     = v_cnt_q < V_ACT;
    end

    // Counter advance; a low enable parks the raster at the origin
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        seg_d   = seg_q;
        bar_d   = bar_q;
        if (!bus.en) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
            seg_d   = '0;
            bar_d   = '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
            seg_d   = '0;
            bar_d   = '0;
        end else begin
            h_cnt_d = h_cnt_q + CW'(1);
            if (seg_q == BAR_LAST) begin
                seg_d = '0;
                bar_d = bar_q + BW'(1);
            end else begin
                seg_d = seg_q + CW'(1);
            end
        end
    end

    always_comb begin
        bar_rgb_c = 24'h000000;
        case (bar1_q)
            3'd0:    bar_rgb_c = 24'hFFFFFF;
            3'd1:    bar_rgb_c = 24'hFFFF00;
            3'd2:    bar_rgb_c = 24'h00FFFF;
            3'd3:    bar_rgb_c = 24'h00FF00;
            3'd4:    bar_rgb_c = 24'hFF00FF;
            3'd5:    bar_rgb_c = 24'hFF0000;
            3'd6:    bar_rgb_c = 24'h0000FF;
            default: bar_rgb_c = 24'h000000;
        endcase
    end

    // Pipeline next-state; disabling flushes every stage to idle/inactive at once
    always_comb begin
        pix_req_d     = 1'b0;
        req_x_d       = '0;
        req_y_d       = '0;
        frame_start_d = 1'b0;
        hs0_d         = ~HS_POL;
        vs0_d         = ~VS_POL;
        bar0_d        = '0;
        de1_d         = 1'b0;
        hs1_d         = ~HS_POL;
        vs1_d         = ~VS_POL;
        bar1_d        = '0;
        de_d          = 1'b0;
        hsync_d       = ~HS_POL;
        vsync_d       = ~VS_POL;
        rgb_d         = '0;
        pat_d         = pat_q;
        if (bus.en) begin
            pix_req_d     = h_act_c && v_act_c;
            req_x_d       = pix_req_d ? h_cnt_q : '0;
            req_y_d       = pix_req_d ? v_cnt_q : '0;
            frame_start_d = at_origin_c;
            if (at_origin_c) begin
                pat_d = bus.pattern_sel;
            end
            hs0_d   = (h_cnt_q >= HS_BEG && h_cnt_q < HS_END) ? HS_POL : ~HS_POL;
            vs0_d   = (v_cnt_q >= VS_BEG && v_cnt_q < VS_END) ? VS_POL : ~VS_POL;
            bar0_d  = bar_q;
            de1_d   = pix_req_q;
            hs1_d   = hs0_q;
            vs1_d   = vs0_q;
            bar1_d  = bar0_q;
            de_d    = de1_q;
            hsync_d = hs1_q;
            vsync_d = vs1_q;
            if (de1_q) begin
                rgb_d = pat_q ? bar_rgb_c : bus.rgb_in;
            end
        end
    end

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            seg_q         <= '0;
            bar_q         <= '0;
            pix_req_q     <= 1'b0;
            req_x_q       <= '0;
            req_y_q       <= '0;
            frame_start_q <= 1'b0;
            hs0_q         <= ~HS_POL;
            vs0_q         <= ~VS_POL;
            bar0_q        <= '0;
            de1_q         <= 1'b0;
            hs1_q         <= ~HS_POL;
            vs1_q         <= ~VS_POL;
            bar1_q        <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            rgb_q         <= '0;
            pat_q         <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            seg_q         <= seg_d;
            bar_q         <= bar_d;
            pix_req_q     <= pix_req_d;
            req_x_q       <= req_x_d;
            req_y_q       <= req_y_d;
            frame_start_q <= frame_start_d;
            hs0_q         <= hs0_d;
            vs0_q         <= vs0_d;
            bar0_q        <= bar0_d;
            de1_q         <= de1_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            bar1_q        <= bar1_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            pat_q         <= pat_d;
        end
    end

    assign bus.pix_req     = pix_req_q;
    assign bus.req_x       = req_x_q;
    assign bus.req_y       = req_y_q;
    assign bus.frame_start = frame_start_q;
    assign bus.de_out      = de_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.rgb_out     = rgb_q;
endmodule

// File: tb/tb_dvi_timing_gen.sv
// Directed bench for dvi_timing_gen: 640-pixel lines with a short 11-line frame (8800 cycles).
module tb_dvi_timing_gen;
    logic clkin;
    logic rstin;
    int   cyc;
    int   n_checks;
    int   n_errors;

    bit   mon_on;
    bit   exp_pat;
    int   mon_err;
    int   mon_px;

    dvi_timing_gen_if bus ();

    dvi_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(6),   .V_FP(1),  .V_SYNC(2),  .V_BP(2),
        .HS_POL(1'b0),  .VS_POL(1'b0)
    ) dut (
        .clkin(clkin),
        .rstin(rstin),
        .bus  (bus)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    always @(posedge clkin or posedge rstin) begin
        if (rstin) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Frame source with a fixed one-cycle read latency; pixel value encodes its position
    always @(posedge clkin) begin
        bus.rgb_in <= bus.pix_req ? {bus.req_y, bus.req_x} : 24'h000000;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clkin);
    endtask

    function automatic logic [23:0] bar_color(input int x);
        case (x / 80)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Stream monitor: independent raster model for requests, 2-cycle history for outputs
    int          mx, my;
    bit          m_valid, exp_req;
    logic        pr1, pr2;
    logic [11:0] x1, x2, y1, y2;
    logic [23:0] exp_rgb;
    always @(posedge clkin) begin
        #1;
        if (!mon_on) begin
            m_valid = 1'b0;
            pr1 = 1'b0; pr2 = 1'b0;
            x1 = '0; x2 = '0; y1 = '0; y2 = '0;
        end else begin
            if (m_valid) begin
                if (mx == 799) begin
                    mx = 0;
                    my = (my == 10) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
            if (bus.frame_start === 1'b1) begin
                if (m_valid && (mx != 0 || my != 0)) mon_err++;
                mx = 0; my = 0; m_valid = 1'b1;
            end else if (m_valid && mx == 0 && my == 0) begin
                mon_err++;
            end
            if (m_valid) begin
                exp_req = (mx < 640) && (my < 6);
                if (bus.pix_req !== exp_req) mon_err++;
                if (bus.req_x !== (exp_req ? 12'(mx) : 12'd0)) mon_err++;
                if (bus.req_y !== (exp_req ? 12'(my) : 12'd0)) mon_err++;
            end
            if (bus.de_out !== pr2) mon_err++;
            if (bus.de_out === 1'b1) begin
                mon_px++;
                exp_rgb = exp_pat ? bar_color(int'(x2)) : {y2, x2};
                if (bus.rgb_out !== exp_rgb) mon_err++;
            end else if (bus.rgb_out !== 24'h000000) begin
                mon_err++;
            end
            pr2 = pr1; x2 = x1; y2 = y1;
            pr1 = bus.pix_req; x1 = bus.req_x; y1 = bus.req_y;
        end
    end

    int          fs1, fs2, de_first, hs_fall1, hs_rise1, hs_fall2, vs_fall;
    int          de_bursts, de_cyc, vs_low, hs_falls;
    logic        pde, phs, pvs;
    int          bx[10]   = '{0, 79, 80, 160, 240, 320, 400, 480, 560, 639};
    logic [23:0] bexp[10] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000};

    initial begin
        n_checks = 0; n_errors = 0; mon_err = 0; mon_px = 0;
        mon_on = 1'b0; exp_pat = 1'b0;
        rstin = 1'b1; bus.en = 1'b1; bus.pattern_sel = 1'b0;
        repeat (3) @(negedge clkin);

        check("rst_pix_req", 32'(bus.pix_req), 32'd0);
        check("rst_frame_start", 32'(bus.frame_start), 32'd0);
        check("rst_req_x", 32'(bus.req_x), 32'd0);
        check("rst_req_y", 32'(bus.req_y), 32'd0);
        check("rst_de", 32'(bus.de_out), 32'd0);
        check("rst_rgb", 32'(bus.rgb_out), 32'd0);
        check("rst_hsync", 32'(bus.hsync), 32'd1);
        check("rst_vsync", 32'(bus.vsync), 32'd1);

        rstin = 1'b0;
        mon_on = 1'b1;

        // First frame: measure raster structure
        fs1 = -1; fs2 = -1; de_first = -1; hs_fall1 = -1; hs_rise1 = -1; hs_fall2 = -1; vs_fall = -1;
        de_bursts = 0; de_cyc = 0; vs_low = 0; hs_falls = 0;
        pde = 1'b0; phs = 1'b1; pvs = 1'b1;
        for (int c = 1; c <= 8801; c++) begin
            wait_cyc(c);
            if (bus.frame_start === 1'b1) begin
                if (fs1 < 0) fs1 = c;
                else if (fs2 < 0) fs2 = c;
            end
            if (c <= 8800) begin
                if (bus.de_out === 1'b1) de_cyc++;
                if (bus.de_out === 1'b1 && !pde) begin
                    de_bursts++;
                    if (de_first < 0) de_first = c;
                end
                if (bus.hsync === 1'b0 && phs) begin
                    hs_falls++;
                    if (hs_fall1 < 0) hs_fall1 = c;
                    else if (hs_fall2 < 0) hs_fall2 = c;
                end
                if (bus.hsync === 1'b1 && !phs && hs_rise1 < 0) hs_rise1 = c;
                if (bus.vsync === 1'b0) vs_low++;
                if (bus.vsync === 1'b0 && pvs && vs_fall < 0) vs_fall = c;
            end
            if (c == 4) check("rgb_first_px1", 32'(bus.rgb_out), 32'h000001);
            pde = bus.de_out; phs = bus.hsync; pvs = bus.vsync;
        end
        check("frame_start_first", 32'(fs1), 32'd1);
        check("frame_start_period", 32'(fs2), 32'd8801);
        check("de_first", 32'(de_first), 32'd3);
        check("de_bursts", 32'(de_bursts), 32'd6);
        check("de_cycles", 32'(de_cyc), 32'd3840);
        check("hs_fall_first", 32'(hs_fall1), 32'd659);
        check("hs_rise_first", 32'(hs_rise1), 32'd755);
        check("hs_period", 32'(hs_fall2), 32'd1459);
        check("hs_per_frame", 32'(hs_falls), 32'd11);
        check("vs_fall", 32'(vs_fall), 32'd5603);
        check("vs_low_cycles", 32'(vs_low), 32'd1600);

        // Mid-frame request for bars: frame 2 stays pass-through, frame 3 shows bars
        bus.pattern_sel = 1'b1;
        wait_cyc(16000);
        exp_pat = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_cyc(17603 + bx[i]);
            check($sformatf("bar_x%0d", bx[i]), 32'(bus.rgb_out), 32'(bexp[i]));
        end
        wait_cyc(17603 + 640);
        check("bar_de_end", 32'(bus.de_out), 32'd0);
        wait_cyc(18000);
        bus.pattern_sel = 1'b0;
        wait_cyc(17603 + 800 + 100);
        check("bar_hold_line1", 32'(bus.rgb_out), 32'hFFFF00);
        wait_cyc(25000);
        exp_pat = 1'b0;
        wait_cyc(26408);
        check("pass_after_bars", 32'(bus.rgb_out), 32'h000005);

        // Drop enable at (300,3)
        wait_cyc(29101);
        check("req_before_drop", 32'({bus.pix_req, bus.req_y, bus.req_x}), 32'h100312C);
        bus.en = 1'b0;
        mon_on = 1'b0;
        wait_cyc(29102);
        check("drop_de", 32'(bus.de_out), 32'd0);
        check("drop_rgb", 32'(bus.rgb_out), 32'd0);
        check("drop_syncs", 32'({bus.hsync, bus.vsync}), 32'd3);
        check("drop_pix_req", 32'(bus.pix_req), 32'd0);
        wait_cyc(29104);
        check("drop_de_hold", 32'(bus.de_out), 32'd0);
        wait_cyc(29106);
        mon_on = 1'b1;
        bus.en = 1'b1;
        wait_cyc(29107);
        check("resume_frame_start", 32'(bus.frame_start), 32'd1);
        check("resume_req_xy", 32'({bus.req_y, bus.req_x}), 32'd0);
        wait_cyc(29109);
        check("resume_de", 32'(bus.de_out), 32'd1);
        wait_cyc(29110);
        check("resume_rgb_px1", 32'(bus.rgb_out), 32'h000001);
        wait_cyc(37906);
        check("resume_no_early_fs", 32'(bus.frame_start), 32'd0);
        wait_cyc(37907);
        check("resume_next_fs", 32'(bus.frame_start), 32'd1);

        // Asynchronous reset in the middle of an active line
        wait_cyc(38009);
        check("pre_reset_de", 32'(bus.de_out), 32'd1);
        mon_on = 1'b0;
        rstin = 1'b1;
        #1;
        check("async_de", 32'(bus.de_out), 32'd0);
        check("async_rgb", 32'(bus.rgb_out), 32'd0);
        check("async_syncs", 32'({bus.hsync, bus.vsync}), 32'd3);
        check("async_req", 32'({bus.pix_req, bus.frame_start, bus.req_x}), 32'd0);
        @(negedge clkin);
        @(negedge clkin);
        rstin = 1'b0;
        mon_on = 1'b1;
        wait_cyc(1);
        check("rst_restart_fs", 32'(bus.frame_start), 32'd1);
        wait_cyc(3);
        check("rst_restart_de", 32'(bus.de_out), 32'd1);
        wait_cyc(8801);
        check("rst_restart_next_fs", 32'(bus.frame_start), 32'd1);
        @(negedge clkin);

        check("stream_errors", 32'(mon_err), 32'd0);
        check("stream_active", 32'(mon_px >= 15000), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dvi_timing_gen.md
# dvi_timing_gen

Video timing and pixel-fetch front end for the DVI transmit path. Generates raster counters, HSYNC/VSYNC/DE and a one-cycle-ahead pixel request to the frame source. Outputs registered 24-bit RGB aligned with the sync/DE signals; the three TMDS channel encoders consume these directly (blue channel: c0=hsync, c1=vsync). A built-in colour-bar mode allows bring-up without a frame source.

## Interface
- H_ACTIVE, 640, active pixels per line (multiple of 8, ≥8)
- H_FP, 16, horizontal front porch (≥1)
- H_SYNC, 96, hsync width (≥1)
- H_BP, 48, horizontal back porch (≥1)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines, ≥1)
- V_SYNC, 2, vsync width (lines, ≥1)
- V_BP, 33, vertical back porch (lines, ≥1)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- clkin  in  1  pixel clock
- rstin  in  1  reset, asynchronous, active-high
- en  in  1  run enable; low holds the raster idle
- pattern_sel  in  1  0 = pass rgb_in, 1 = internal colour bars
- rgb_in  in  24  pixel from source {R,G,B}, valid the cycle after pix_req
- pix_req  out  1  pixel request for (req_x, req_y)
- req_x  out  12  column of requested pixel
- req_y  out  12  line of requested pixel
- frame_start  out  1  one-cycle pulse with the request for (0,0)
- rgb_out  out  24  pixel to encoders {R,G,B}
- de_out  out  1  data enable to encoders
- hsync  out  1  horizontal sync to encoder c0
- vsync  out  1  vertical sync to encoder c1

## Operation
- h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800), v_cnt 0..V_TOTAL-1 (525). h_cnt wraps to 0 and v_cnt increments; v_cnt wraps to 0 after V_TOTAL-1 at line end.
- Line regions by h_cnt: ACTIVE [0,H_ACTIVE), FP, SYNC [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), BP. Frame regions by v_cnt likewise. vsync changes only at h_cnt=0.
- Stage 0 (registered from counters): pix_req = h and v in ACTIVE; req_x=h_cnt, req_y=v_cnt when pix_req, else 0; frame_start = (h_cnt,v_cnt)=(0,0).
- Stage 1: internal delay of de, syncs and colour-bar index.
- Stage 2 (outputs): de_out, hsync, vsync, rgb_out. rgb_out = selected pixel when de_out=1, else 24'h0.
- rgb_in sampled at the edge ending the cycle after pix_req; sources must meet this fixed 1-cycle read latency (block RAM compatible).
- Colour bars: 8 bars of H_ACTIVE/8 pixels from x=0: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Bar index derived by a per-line segment counter (no divider), reset at x=0.
- pattern_sel latched only at frame_start; mid-frame changes take effect from the next frame.
- en low (sampled at each edge): counters forced to (0,0); pix_req/frame_start 0; pipeline flushes so within 2 cycles de_out=0, syncs inactive, rgb_out=0. On en rising, first frame_start appears 1 cycle later; raster restarts at (0,0), never mid-frame.

## Timing
- Reset (async): counters 0; pix_req, req_x, req_y, frame_start, de_out, rgb_out = 0; hsync=~HS_POL, vsync=~VS_POL; latched pattern_sel=0.
- Latency: pix_req/req_x/req_y in cycle N -> de_out/rgb_out for that pixel in cycle N+2. hsync/vsync carry the same 2-cycle offset from counters, so sync/DE relationship at the output equals the programmed raster.
- Per line: de_out high exactly H_ACTIVE consecutive cycles on active lines, zero on blanking lines; hsync active exactly H_SYNC cycles, beginning H_FP cycles after de_out falls.
- Per frame: vsync active exactly V_SYNC×H_TOTAL cycles; period H_TOTAL×V_TOTAL = 420000 cycles default.
- Reset deasserted mid-line: raster starts at (0,0) on first enabled edge.

## Test plan
- Reset with en=1, pattern_sel=0: after release, frame_start at cycle 1, first de_out at cycle 3 with rgb_out = rgb_in value driven the cycle after pix_req; de_out high 640 cycles, hsync low cycles 659..754 of the line (relative to pix_req origin +2).
- Full frame count: measure 800 cycles per hsync period, 525 hsync per vsync, vsync low exactly 1600 cycles, 480 DE bursts per frame, next frame_start 420000 cycles later.
- Latency/ordering: drive rgb_in = {req_y[11:0], req_x[11:0]} delayed one cycle; check every rgb_out equals its (x,y) and de_out never asserts outside active area.
- Colour bars: pattern_sel=1 before frame_start; line 0 rgb_out = FFFFFF for x 0..79, FFFF00 for x 80..159, ..., 000000 for x 560..639; toggling pattern_sel mid-frame leaves current frame unchanged.
- en dropped at (x=300,y=100): within 2 cycles de_out=0, hsync=vsync=1, rgb_out=0; en re-raised -> frame_start next cycle, raster resumes at (0,0).
- Async reset mid-active line: outputs immediately at reset values without a clock edge; clean restart afterwards.
